// File: rtl/mult_seq_ctrl.sv
// Purpose: queues operand pairs, sequences the 8x8 shift-add multiplier, captures and accumulates its products.
// Latency: 12 cycles from an accepted push (idle, empty) to out_valid; one result every 11 cycles when streaming.
// Backpressure: in_ready = operand FIFO not full; out_* held until out_ready, which stalls further starts.
module mult_seq_ctrl #(
    parameter int DEPTH = 4,
    parameter int ACC_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    input  logic             in_acc,
    output logic             mult_start,
    output logic [7:0]       mult_a,
    output logic [7:0]       mult_b,
    input  logic             mult_ready,
    input  logic [15:0]      mult_product,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_product,
    output logic [ACC_W-1:0] out_acc,
    output logic             busy
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic       acc;
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    // Operand FIFO storage and pointers
    op_t            mem_q [DEPTH];
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           full, empty, push, pop;
    op_t            head;

    // Sequencer state and registered datapath
    state_t         state_q, state_d;
    logic           mult_start_q, mult_start_d;
    logic [7:0]     mult_a_q, mult_a_d;
    logic [7:0]     mult_b_q, mult_b_d;
    logic           flag_q, flag_d;
    logic           out_valid_q, out_valid_d;
    logic [15:0]    out_product_q, out_product_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] acc_sum;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    // A full FIFO refuses the push even if the sequencer pops in the same cycle.
    assign push  = in_valid && !full;
    assign head  = mem_q[rd_ptr_q];

    // Operand storage write; contents need no reset since pointers define validity
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{a: in_a, b: in_b, acc: in_acc};
        end
    end

    // FIFO pointer and occupancy next-state; pointers wrap naturally at DEPTH
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    // FIFO pointer registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Sequencer state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Sequencer next state and FIFO pop decision
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = S_START;
                end
            end
            // mult_ready may still be high from the previous op here, so it is not looked at.
            S_START: state_d = S_WAIT;
            S_WAIT: begin
                if (mult_ready) begin
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next values: operand load on pop, product capture and accumulate at end of WAIT
    always_comb begin
        mult_a_d      = mult_a_q;
        mult_b_d      = mult_b_q;
        flag_d        = flag_q;
        out_product_d = out_product_q;
        acc_d         = acc_q;
        acc_sum       = acc_q + ACC_W'(mult_product);
        if (pop) begin
            mult_a_d = head.a;
            mult_b_d = head.b;
            flag_d   = head.acc;
        end
        if (state_q == S_WAIT && mult_ready) begin
            out_product_d = mult_product;
            acc_d         = flag_q ? acc_sum : ACC_W'(mult_product);
        end
        mult_start_d = (state_d == S_START);
        out_valid_d  = (state_d == S_OUT);
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mult_start_q  <= 1'b0;
            mult_a_q      <= '0;
            mult_b_q      <= '0;
            flag_q        <= 1'b0;
            out_valid_q   <= 1'b0;
            out_product_q <= '0;
            acc_q         <= '0;
        end else begin
            mult_start_q  <= mult_start_d;
            mult_a_q      <= mult_a_d;
            mult_b_q      <= mult_b_d;
            flag_q        <= flag_d;
            out_valid_q   <= out_valid_d;
            out_product_q <= out_product_d;
            acc_q         <= acc_d;
        end
    end

    assign in_ready    = !full;
    assign mult_start  = mult_start_q;
    assign mult_a      = mult_a_q;
    assign mult_b      = mult_b_q;
    assign out_valid   = out_valid_q;
    assign out_product = out_product_q;
    // The accumulator only changes at capture, so it doubles as the held out_acc value.
    assign out_acc     = acc_q;
    assign busy        = (state_q != S_IDLE) || !empty;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
module tb_mult_seq_ctrl;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, in_valid, in_acc, out_ready;
    logic [7:0]  in_a, in_b;
    logic        in_ready, mult_start, out_valid, busy;
    logic [7:0]  mult_a, mult_b;
    logic [15:0] out_product;
    logic [23:0] out_acc;
    logic        in_ready16, mult_start16, out_valid16, busy16;
    logic [7:0]  mult_a16, mult_b16;
    logic [15:0] out_product16, out_acc16;
    logic        mult_ready;
    logic [15:0] mult_product;

    mult_seq_ctrl #(.DEPTH(DEPTH), .ACC_W(24)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_acc(in_acc),
        .mult_start(mult_start), .mult_a(mult_a), .mult_b(mult_b),
        .mult_ready(mult_ready), .mult_product(mult_product),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_product(out_product), .out_acc(out_acc), .busy(busy)
    );

    mult_seq_ctrl #(.DEPTH(DEPTH), .ACC_W(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready16),
        .in_a(in_a), .in_b(in_b), .in_acc(in_acc),
        .mult_start(mult_start16), .mult_a(mult_a16), .mult_b(mult_b16),
        .mult_ready(mult_ready), .mult_product(mult_product),
        .out_valid(out_valid16), .out_ready(out_ready),
        .out_product(out_product16), .out_acc(out_acc16), .busy(busy16)
    );

    // Behavioural multiplier: not reset, ready low the cycle after start, high 9 cycles after start.
    int          mcnt = 8;
    logic [15:0] mprod = 16'h0;
    always @(posedge clk) begin
        if (mult_start) begin
            mcnt  <= 0;
            mprod <= 16'(mult_a) * 16'(mult_b);
        end else if (mcnt < 8) begin
            mcnt <= mcnt + 1;
        end
    end
    assign mult_ready   = (mcnt >= 8);
    assign mult_product = mult_ready ? mprod : 16'hDEAD;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: bound expired or unexpected event (t=%0t)", name, $time);
    endtask

    // Reference model: results are in push order; accumulator follows the push-order flags.
    logic [7:0] iss_a[$];
    logic [7:0] iss_b[$];
    int         exp_p[$];
    longint     exp_acc[$];
    longint     model_acc = 0;
    int         res_p[$];
    int         res_a[$];
    int         res_a16[$];
    int         hs_cyc[$];
    logic       prev_stall = 1'b0;
    logic       prev_start = 1'b0;
    logic [15:0] prev_p = '0;
    logic [23:0] prev_acc = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            iss_a.delete(); iss_b.delete(); exp_p.delete(); exp_acc.delete();
            model_acc  = 0;
            prev_stall = 1'b0;
            prev_start = 1'b0;
        end else begin
            chk("acc16_lockstep",
                {mult_start, mult_a, mult_b, out_valid, out_product, in_ready, busy} ===
                {mult_start16, mult_a16, mult_b16, out_valid16, out_product16, in_ready16, busy16}, 1);
            if (mult_start) begin
                chk("start_single_cycle", prev_start, 0);
                if (iss_a.size() == 0) begin
                    fail_now("start_without_operands");
                end else begin
                    chk("mult_a", mult_a, iss_a.pop_front());
                    chk("mult_b", mult_b, iss_b.pop_front());
                end
            end
            if (prev_stall) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_product", out_product, prev_p);
                chk("stall_acc", out_acc, prev_acc);
            end
            if (out_valid && out_ready) begin
                if (exp_p.size() == 0) begin
                    fail_now("result_without_operands");
                end else begin
                    longint ea;
                    ea = exp_acc.pop_front();
                    chk("out_product", out_product, exp_p.pop_front());
                    chk("out_acc", out_acc, ea % (64'sd1 << 24));
                    chk("out_acc16", out_acc16, ea % (64'sd1 << 16));
                    res_p.push_back(int'(out_product));
                    res_a.push_back(int'(out_acc));
                    res_a16.push_back(int'(out_acc16));
                    hs_cyc.push_back(cyc);
                end
            end
            if (in_valid && in_ready) begin
                int p;
                p = int'(in_a) * int'(in_b);
                model_acc = in_acc ? model_acc + p : longint'(p);
                iss_a.push_back(in_a);
                iss_b.push_back(in_b);
                exp_p.push_back(p);
                exp_acc.push_back(model_acc);
            end
            prev_stall = out_valid && !out_ready;
            prev_start = mult_start;
            prev_p     = out_product;
            prev_acc   = out_acc;
        end
    end

    function automatic void clear_log();
        res_p.delete(); res_a.delete(); res_a16.delete(); hs_cyc.delete();
    endfunction

    // All driver tasks start and end 1 time unit after a rising edge.
    task automatic push(input logic [7:0] a, input logic [7:0] b, input logic ac);
        bit done;
        done = 0;
        in_a = a; in_b = b; in_acc = ac; in_valid = 1'b1;
        for (int k = 0; k < 300 && !done; k++) begin
            @(negedge clk);
            done = in_ready;
            @(posedge clk); #1;
        end
        if (!done) fail_now("push_timeout");
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((exp_p.size() != 0 || busy || out_valid) && k < 3000) begin
            @(posedge clk); #1;
            k++;
        end
        if (k >= 3000) fail_now("drain_timeout");
    endtask

    task automatic single_op(input logic [7:0] a, input logic [7:0] b, input logic ac,
                             input int ep, input int ea);
        int first_ov, n_start, start_k;
        first_ov = -1; n_start = 0; start_k = -1;
        in_a = a; in_b = b; in_acc = ac; in_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (k == 0) chk("op_accept", in_ready, 1);
            if (mult_start) begin
                n_start++;
                start_k = k;
            end
            if (out_valid && first_ov < 0) begin
                first_ov = k;
                chk("op_product_lit", out_product, ep);
                chk("op_acc_lit", out_acc, ea);
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
        chk("op_start_count", n_start, 1);
        chk("op_start_cycle", start_k, 2);
        chk("op_valid_cycle", first_ov, 12);
        @(negedge clk);
        chk("op_busy_after", busy, 0);
        chk("op_valid_after", out_valid, 0);
        @(posedge clk); #1;
    endtask

    int bp_a[6] = '{11, 22, 33, 44, 55, 66};
    int bp_b[6] = '{3, 5, 7, 9, 250, 128};

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nacc, n_ov;
        bit acc_now;
        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_acc = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_mult_start", mult_start, 0);
        chk("rst_mult_a", mult_a, 0);
        chk("rst_mult_b", mult_b, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_product", out_product, 0);
        chk("rst_out_acc", out_acc, 0);
        @(posedge clk); #1;

        // Single operation latency
        single_op(8'd12, 8'd10, 1'b0, 120, 120);

        // Back-to-back accumulate; 16-bit instance wraps on the second result
        clear_log();
        push(8'd255, 8'd255, 1'b0);
        push(8'd255, 8'd255, 1'b1);
        push(8'd2, 8'd3, 1'b1);
        drain();
        chk("b2b_count", res_p.size(), 3);
        if (res_p.size() == 3) begin
            chk("b2b_p0", res_p[0], 65025);  chk("b2b_a0", res_a[0], 65025);
            chk("b2b_p1", res_p[1], 65025);  chk("b2b_a1", res_a[1], 130050);
            chk("b2b_p2", res_p[2], 6);      chk("b2b_a2", res_a[2], 130056);
            chk("wrap16_a1", res_a16[1], 64514);
            chk("b2b_gap1", hs_cyc[1] - hs_cyc[0], 11);
            chk("b2b_gap2", hs_cyc[2] - hs_cyc[1], 11);
        end

        // FIFO full with the consumer stalled
        clear_log();
        out_ready = 1'b0;
        nacc = 0;
        for (int k = 0; k < 10; k++) begin
            in_a = 8'(bp_a[nacc]); in_b = 8'(bp_b[nacc]); in_acc = 1'b1;
            in_valid = 1'b1;
            @(negedge clk);
            acc_now = in_ready;
            @(posedge clk); #1;
            if (acc_now) nacc++;
        end
        in_valid = 1'b0;
        chk("bp_accepted", nacc, 5);
        repeat (30) @(posedge clk);
        #1;
        @(negedge clk);
        chk("bp_in_ready_low", in_ready, 0);
        chk("bp_stall_valid", out_valid, 1);
        chk("bp_stall_product", out_product, bp_a[0] * bp_b[0]);
        @(posedge clk); #1;
        out_ready = 1'b1;
        drain();
        chk("bp_count", res_p.size(), 5);
        for (int j = 0; j < 5 && j < res_p.size(); j++) chk("bp_order", res_p[j], bp_a[j] * bp_b[j]);

        // Zero and unit operands
        clear_log();
        push(8'd0, 8'd200, 1'b0);
        push(8'd200, 8'd0, 1'b1);
        push(8'd1, 8'd1, 1'b1);
        drain();
        chk("zero_count", res_p.size(), 3);
        if (res_p.size() == 3) begin
            chk("zero_p0", res_p[0], 0); chk("zero_p1", res_p[1], 0); chk("zero_p2", res_p[2], 1);
            chk("zero_a2", res_a[2], 1);
        end

        // Reset in the middle of WAIT
        in_a = 8'd5; in_b = 8'd6; in_acc = 1'b1; in_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k == 0) chk("rw_accept", in_ready, 1);
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rw_out_valid", out_valid, 0);
        chk("rw_out_product", out_product, 0);
        chk("rw_out_acc", out_acc, 0);
        chk("rw_mult_start", mult_start, 0);
        chk("rw_mult_a", mult_a, 0);
        chk("rw_mult_b", mult_b, 0);
        chk("rw_busy", busy, 0);
        chk("rw_in_ready", in_ready, 1);
        n_ov = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (out_valid) n_ov++;
        end
        chk("rw_no_result", n_ov, 0);
        @(posedge clk); #1;
        single_op(8'd7, 8'd9, 1'b0, 63, 63);

        // Randomized traffic with random consumer backpressure
        for (int k = 0; k < 900; k++) begin
            in_valid  = ($urandom_range(0, 2) != 0);
            in_a      = 8'($urandom_range(0, 255));
            in_b      = 8'($urandom_range(0, 255));
            in_acc    = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 6);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();
        @(negedge clk);
        chk("final_busy", busy, 0);
        chk("final_out_valid", out_valid, 0);
        chk("final_pending_starts", iss_a.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
